// File: rtl/nap_stream_pkg.sv
// rtl/nap_stream_pkg.sv - shared LFSR, lane rule and ID types for the NAP stream sender/checker
package nap_stream_pkg;

  // Galois feedback mask for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

  typedef logic [3:0] src_id_t;

  // Checker FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOP = 2'd1;
  localparam logic [1:0] ST_IN_PKT   = 2'd2;

  // One Galois step; sender and checker must use the same function to stay in lockstep
  function automatic logic [31:0] lfsr32_next(input logic [31:0] cur);
    lfsr32_next = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR32_TAPS : 32'h0);
  endfunction

  // Each 32-bit lane carries the LFSR word XORed with its lane number
  function automatic logic [31:0] lane_word(input logic [31:0] lfsr, input logic [7:0] lane);
    lane_word = lfsr ^ {24'h0, lane};
  endfunction

endpackage

// File: rtl/lfsr32_gen.sv
// rtl/lfsr32_gen.sv - 32-bit Galois LFSR with seed load and advance enable
module lfsr32_gen
  import nap_stream_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2D22
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [31:0] o_value
);

  // Reload takes priority over advance so a restart always begins at the seed
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_value <= SEED;
    end else if (i_load) begin
      o_value <= SEED;
    end else if (i_advance) begin
      o_value <= lfsr32_next(o_value);
    end
  end

endmodule

// File: rtl/nap_stream_rx_checker.sv
// rtl/nap_stream_rx_checker.sv - NAP stream receive checker; RX_CHK_BACKPRESSURE_EN adds random ready masking
module nap_stream_rx_checker
  import nap_stream_pkg::*;
#(
  parameter int          DATA_WIDTH    = 256,
  parameter int          BEATS_PER_PKT = 8,
  parameter int          NUM_PKTS      = 1024,
  parameter src_id_t     EXP_SRC_ID    = 4'h9,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2D22
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_sop,
  input  logic                  i_rx_eop,
  input  src_id_t               i_rx_src,
  output logic                  o_fail,
  output logic                  o_done,
  output logic [31:0]           o_pkt_count,
  output logic [15:0]           o_err_count
);

  localparam int          LANES    = DATA_WIDTH / 32;
  localparam logic [7:0]  LAST_IDX = 8'(BEATS_PER_PKT - 1);
  localparam logic [31:0] DONE_AT  = 32'(NUM_PKTS);

  logic                  accept;
  logic [31:0]           lfsr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  data_err;
  logic                  src_err;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [7:0]            beat_cnt;
  logic [7:0]            beat_cnt_nxt;
  logic                  frame_err;
  logic                  pkt_end;
  logic                  beat_err_q;
  logic                  pkt_end_q;
  logic                  bp_open;

  assign accept = i_rx_valid & o_rx_ready;

  lfsr32_gen #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (1'b0),
    .i_advance (accept),
    .o_value   (lfsr)
  );

`ifdef RX_CHK_BACKPRESSURE_EN
  logic [15:0] bp_lfsr;

  // Free-running 16-bit LFSR; ready is masked whenever its low two bits are zero
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bp_lfsr <= 16'hACE1;
    end else begin
      bp_lfsr <= {1'b0, bp_lfsr[15:1]} ^ (bp_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign bp_open = (bp_lfsr[1:0] != 2'b00);
`else
  assign bp_open = 1'b1;
`endif

  // Ready is a pure register so the NAP sees a clean, glitch-free handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rx_ready <= 1'b0;
    end else begin
      o_rx_ready <= i_start & ~o_done & bp_open;
    end
  end

  // Expected beat regenerated from the current LFSR word, one lane at a time
  always_comb begin
    exp_data = '0;
    for (int k = 0; k < LANES; k++) begin
      exp_data[k*32 +: 32] = lane_word(lfsr, 8'(k));
    end
  end

  assign data_err = (i_rx_data != exp_data);
  assign src_err  = (i_rx_src != EXP_SRC_ID);

  // Framing FSM: a leading sop restarts the packet, the last index closes it either way
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    frame_err    = 1'b0;
    pkt_end      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_WAIT_SOP;
        end
      end
      ST_WAIT_SOP: begin
        if (accept) begin
          if (i_rx_sop && !i_rx_eop) begin
            state_nxt    = ST_IN_PKT;
            beat_cnt_nxt = 8'd1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      ST_IN_PKT: begin
        if (accept) begin
          if (i_rx_sop) begin
            frame_err = 1'b1;
            if (i_rx_eop) begin
              state_nxt    = ST_WAIT_SOP;
              beat_cnt_nxt = 8'd0;
            end else begin
              beat_cnt_nxt = 8'd1;
            end
          end else if (beat_cnt == LAST_IDX) begin
            pkt_end      = 1'b1;
            frame_err    = ~i_rx_eop;
            state_nxt    = ST_WAIT_SOP;
            beat_cnt_nxt = 8'd0;
          end else if (i_rx_eop) begin
            pkt_end      = 1'b1;
            frame_err    = 1'b1;
            state_nxt    = ST_WAIT_SOP;
            beat_cnt_nxt = 8'd0;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        beat_cnt_nxt = 8'd0;
      end
    endcase
  end

  // FSM state and beat counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      beat_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Compare stage: fold all per-beat checks into one error bit per accepted beat
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      beat_err_q <= 1'b0;
      pkt_end_q  <= 1'b0;
    end else begin
      beat_err_q <= accept & (data_err | src_err | frame_err);
      pkt_end_q  <= pkt_end;
    end
  end

  // Result stage: sticky flags and counters, done and fail land in the same cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fail      <= 1'b0;
      o_done      <= 1'b0;
      o_pkt_count <= 32'd0;
      o_err_count <= 16'd0;
    end else begin
      if (beat_err_q) begin
        o_fail <= 1'b1;
        if (o_err_count != 16'hFFFF) begin
          o_err_count <= o_err_count + 16'd1;
        end
      end
      if (pkt_end_q) begin
        o_pkt_count <= o_pkt_count + 32'd1;
        if ((NUM_PKTS != 0) && ((o_pkt_count + 32'd1) == DONE_AT)) begin
          o_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nap_stream_rx_checker.sv
// tb/tb_nap_stream_rx_checker.sv - randomized self-checking bench for nap_stream_rx_checker
module tb_nap_stream_rx_checker;

  localparam int          DW   = 256;
  localparam int          BPP  = 8;
  localparam int          NPK  = 16;
  localparam logic [3:0]  SRC  = 4'h9;
  localparam logic [31:0] SEED = 32'hACE1_2D22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic          rdy;
  logic [DW-1:0] rx_data = '0;
  logic          rx_sop = 1'b0;
  logic          rx_eop = 1'b0;
  logic [3:0]    rx_src = 4'h0;
  logic          fail;
  logic          done;
  logic [31:0]   pkt_count;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_lfsr;
  bit          m_in_pkt;
  int          m_idx;
  int          m_err;
  int          m_pkts;
  bit          watch;
  int          watch_n;

  nap_stream_rx_checker #(
    .DATA_WIDTH    (DW),
    .BEATS_PER_PKT (BPP),
    .NUM_PKTS      (NPK),
    .EXP_SRC_ID    (SRC),
    .LFSR_SEED     (SEED)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_start     (start),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rdy),
    .i_rx_data   (rx_data),
    .i_rx_sop    (rx_sop),
    .i_rx_eop    (rx_eop),
    .i_rx_src    (rx_src),
    .o_fail      (fail),
    .o_done      (done),
    .o_pkt_count (pkt_count),
    .o_err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [DW-1:0] make_data(input logic [31:0] s);
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = s ^ 32'(k);
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_in_pkt = 0; m_idx = 0; m_err = 0; m_pkts = 0; watch = 0; watch_n = 0;
  endtask

  // Apply the receive rules to one accepted beat
  task automatic model_accept(input logic [DW-1:0] d, input bit sop, input bit eop,
                              input logic [3:0] src, output bit bad);
    bit ends;
    bad  = (d != make_data(m_lfsr)) || (src != SRC);
    ends = 0;
    if (!m_in_pkt) begin
      if (sop && !eop) begin m_in_pkt = 1; m_idx = 1; end
      else bad = 1;
    end else if (sop) begin
      bad = 1;
      if (eop) m_in_pkt = 0; else m_idx = 1;
    end else if (m_idx == BPP - 1) begin
      ends = 1; m_in_pkt = 0;
      if (!eop) bad = 1;
    end else if (eop) begin
      bad = 1; ends = 1; m_in_pkt = 0;
    end else begin
      m_idx++;
    end
    m_lfsr = lfsr_step(m_lfsr);
    if (bad && m_err < 16'hFFFF) m_err++;
    if (ends) m_pkts++;
  endtask

  // Every cycle boundary goes through here so the fail-latency watch never misses a cycle
  task automatic tick();
    @(negedge clk);
    if (watch) begin
      watch_n++;
      if (watch_n == 1) chk("fail_not_yet", 32'(fail), 32'd0);
      else begin chk("fail_latency", 32'(fail), 32'd1); watch = 0; end
    end
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [3:0] src, input bit corrupt);
    logic [DW-1:0] d;
    bit taken, bad;
    int err_before;
    taken = 0;
    d = make_data(m_lfsr);
    if (corrupt) d[69] = ~d[69];
    rx_valid = 1; rx_data = d; rx_sop = sop; rx_eop = eop; rx_src = src;
    for (int w = 0; w < 100 && !taken; w++) begin
      if (rdy) begin
        err_before = m_err;
        model_accept(d, sop, eop, src, bad);
        if (bad && err_before == 0) begin watch = 1; watch_n = 0; end
        taken = 1;
      end
      tick();
    end
    rx_valid = 0;
    if (!taken) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic stall(input int n);
    int acc;
    acc = 0;
    start = 0; rx_valid = 0;
    tick();
    rx_valid = 1;
    repeat (n) begin
      if (rdy) acc++;
      tick();
    end
    chk("stall_accepts", 32'(acc), 32'd0);
    rx_valid = 0; start = 1;
    tick();
  endtask

  task automatic send_pkt(input int nbeats, input bit last_eop, input int restart_at,
                          input int corrupt_at, input logic [3:0] src, input int pause_at);
    for (int b = 0; b < nbeats; b++) begin
      if (b == pause_at) stall(20);
      send_beat(b == 0 || b == restart_at, last_eop && b == nbeats - 1, src, b == corrupt_at);
      repeat ($urandom_range(0, 1)) tick();
    end
  endtask

  task automatic check_totals(input string ph);
    rx_valid = 0;
    repeat (4) tick();
    chk({ph, "_pkts"}, pkt_count, 32'(m_pkts));
    chk({ph, "_errs"}, 32'(err_count), 32'(m_err));
    chk({ph, "_fail"}, 32'(fail), 32'(m_err != 0));
    chk({ph, "_done"}, 32'(done), 32'(m_pkts >= NPK));
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; rx_valid = 0;
    tick(); tick();
    rst_n = 1;
    model_reset();
    tick();
  endtask

  task automatic go();
    start = 1;
    tick();
  endtask

  initial begin
    int kind, r;
    model_reset();
    do_reset();

    // reset values and ready latency
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pkts", pkt_count, 32'd0);
    chk("rst_errs", 32'(err_count), 32'd0);
    start = 1;
    chk("rdy_before_edge", 32'(rdy), 32'd0);
    tick();
    chk("rdy_latency", 32'(rdy), 32'd1);

    // normal run to done
    for (int p = 0; p < NPK; p++) send_pkt(BPP, 1, -1, -1, SRC, -1);
    check_totals("normal");
    chk("normal_cnt16", pkt_count, 32'd16);
    chk("rdy_after_done", 32'(rdy), 32'd0);

    // data corruption: bit 5 of lane 2 on beat 3 of packet 2
    do_reset(); go();
    for (int p = 0; p < NPK; p++) send_pkt(BPP, 1, -1, (p == 2) ? 3 : -1, SRC, -1);
    check_totals("corrupt");
    chk("corrupt_errs1", 32'(err_count), 32'd1);

    // framing errors
    do_reset(); go();
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    send_pkt(6, 1, -1, -1, SRC, -1);
    check_totals("early_eop");
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    send_pkt(4 + BPP, 1, 4, -1, SRC, -1);
    check_totals("mid_sop");
    send_pkt(BPP, 0, -1, -1, SRC, -1);
    check_totals("no_eop");
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    check_totals("framing");
    chk("framing_errs3", 32'(err_count), 32'd3);

    // source ID mismatch for one whole packet
    do_reset(); go();
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    send_pkt(BPP, 1, -1, -1, 4'h6, -1);
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    check_totals("src");
    chk("src_errs8", 32'(err_count), 32'd8);

    // start dropped mid-packet with valid held high
    do_reset(); go();
    send_pkt(BPP, 1, -1, -1, SRC, 4);
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    check_totals("startstop");
    chk("startstop_pkts2", pkt_count, 32'd2);

    // reset in the middle of a packet, then a clean stream
    do_reset(); go();
    send_pkt(BPP, 1, -1, -1, SRC, -1);
    send_pkt(BPP, 1, -1, 2, SRC, -1);
    check_totals("pre_reset");
    send_pkt(4, 0, -1, -1, SRC, -1);
    #2 rst_n = 0;
    #1;
    chk("midrst_ready", 32'(rdy), 32'd0);
    chk("midrst_fail", 32'(fail), 32'd0);
    chk("midrst_pkts", pkt_count, 32'd0);
    chk("midrst_errs", 32'(err_count), 32'd0);
    start = 0;
    tick();
    rst_n = 1;
    model_reset();
    tick(); go();
    for (int p = 0; p < 3; p++) send_pkt(BPP, 1, -1, -1, SRC, -1);
    check_totals("post_reset");

    // randomized mix of good and faulty packets
    do_reset(); go();
    for (int p = 0; p < 40 && m_pkts < NPK; p++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        2: send_pkt(BPP, 1, -1, $urandom_range(0, BPP - 1), SRC, -1);
        3: send_pkt($urandom_range(2, BPP - 1), 1, -1, -1, SRC, -1);
        4: begin r = $urandom_range(1, BPP - 2); send_pkt(r + BPP, 1, r, -1, SRC, -1); end
        5: send_pkt(BPP, 0, -1, -1, SRC, -1);
        6: send_pkt(BPP, 1, -1, -1, 4'($urandom_range(0, 15)), -1);
        default: send_pkt(BPP, 1, -1, -1, SRC, -1);
      endcase
    end
    check_totals("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nap_stream_rx_checker.md
# nap_stream_rx_checker

Receive-side checker for the horizontal-NAP streaming test path. It sits behind a horizontal NAP's receive interface and accepts packets produced by the matching LFSR stream sender at the far NAP. It regenerates the expected payload locally, checks framing, source ID and data on every accepted beat, and exposes a sticky fail flag for the LED bank plus packet and error counters for the register control block.

## Interface
Parameters:
- DATA_WIDTH, 256, payload width; multiple of 32.
- BEATS_PER_PKT, 8, beats per packet, 2..255.
- NUM_PKTS, 1024, packets until `o_done`; 0 = free-running, `o_done` never asserts.
- EXP_SRC_ID, 4'h9, expected source NAP ID.
- LFSR_SEED, 32'hACE1_2D22, non-zero LFSR reset value.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  checker clock, same domain as the NAP.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  level enable; checking runs while high.
- i_rx_valid  in  1  beat valid from NAP.
- o_rx_ready  out  1  beat ready to NAP, registered.
- i_rx_data  in  DATA_WIDTH  payload.
- i_rx_sop  in  1  first beat of packet.
- i_rx_eop  in  1  last beat of packet.
- i_rx_src  in  4  source NAP ID.
- o_fail  out  1  sticky; set on any error.
- o_done  out  1  sticky; NUM_PKTS packets completed.
- o_pkt_count  out  32  completed packets, wraps.
- o_err_count  out  16  errored beats, saturates at 16'hFFFF.

## Operation
- A beat is accepted when `i_rx_valid & o_rx_ready`.
- `o_rx_ready` is the registered value of `i_start & ~o_done`, ANDed with the backpressure mask when that feature is enabled.
- Expected data: a 32-bit Galois LFSR (x^32+x^22+x^2+x+1). Lane k (32 bits) expects `lfsr ^ {24'h0, k[7:0]}`.
  - The LFSR advances once per accepted beat, including errored beats, so the checker stays in lockstep with the sender.
- States:
  - IDLE: the only state entered from reset. Goes to WAIT_SOP when `i_start` is high.
  - WAIT_SOP: an accepted beat with `sop` goes to IN_PKT with beat counter = 1. An accepted beat without `sop` is a framing error and the state is unchanged.
  - IN_PKT: counts beats. At beat index BEATS_PER_PKT-1, `eop` is required; the packet completes and the state returns to WAIT_SOP.
  - ERR_HOLD: never entered; `o_fail` is a flag, not a state.
- Beat errors (each errored beat increments `o_err_count` at most once):
  - data mismatch;
  - `i_rx_src != EXP_SRC_ID`;
  - `eop` missing at the last beat (counter wraps to 0 and the state returns to WAIT_SOP);
  - `eop` early (state returns to WAIT_SOP);
  - `sop` in IN_PKT (the beat is treated as beat 0 of a new packet).
  - A single-beat `sop & eop` is a framing error.
- A packet with any errored beat still increments `o_pkt_count`.
- `o_done` sets when `o_pkt_count` reaches NUM_PKTS. Ready then drops and stays low until reset.
- `i_start` falling: ready drops on the next cycle. State, LFSR and counters are held, and checking resumes when `i_start` rises again.

## Timing
- Reset values: `o_rx_ready`=0, `o_fail`=0, `o_done`=0, counters=0, LFSR=LFSR_SEED, state=IDLE.
- Compare pipeline: one register stage. `o_fail` and `o_err_count` update 2 cycles after the errored beat is accepted; `o_pkt_count` updates 2 cycles after the eop beat.
- An error on the last beat of the final packet: `o_done` and `o_fail` update in the same cycle.
- Ready-to-accept latency: `o_rx_ready` rises 1 cycle after `i_start` rises.
- Reset asserted mid-packet: everything returns to reset values immediately; the partial packet is discarded.

## Configuration
- RX_CHK_BACKPRESSURE_EN defined: a 16-bit free-running LFSR masks `o_rx_ready` low on roughly 25% of cycles (bits [1:0]==0). This exercises NoC backpressure; check results are identical.
- Undefined: `o_rx_ready` follows `i_start & ~o_done` only.

## Structure
- Shared package `nap_stream_pkg` holds:
  - LFSR polynomial and step function `lfsr32_next()`, shared with the sender;
  - lane-XOR rule;
  - the `src_id_t` typedef (4 bits).
- One sub-module, `lfsr32_gen`: seed load, advance enable, parallel output. Reused by the sender.

## Test plan
- Normal run: 16 good packets with BEATS_PER_PKT=8 and NUM_PKTS=16 -> `o_pkt_count`=16, `o_done`=1, `o_fail`=0, `o_err_count`=0.
- Data corruption: flip bit 5 of lane 2 on beat 3 of packet 2 -> `o_fail` rises 2 cycles later, `o_err_count`=1, `o_pkt_count` still reaches 16.
- Framing errors: eop on beat 5 -> `o_err_count`+1 and state returns to WAIT_SOP; sop on beat 4 -> `o_err_count`+1 and beat counter restarts.
- Source ID mismatch: `i_rx_src`=4'h6 for one whole 8-beat packet -> `o_err_count`=8, `o_fail`=1.
- Start/stop: drop `i_start` mid-packet for 20 cycles with valid held high -> no beats accepted; the packet then completes cleanly and `o_fail`=0.
- Reset mid-packet: assert `i_reset_n`=0 at beat 4 -> all outputs return to 0 and the LFSR reloads LFSR_SEED; a following good stream passes.
